mmu_rsp_merger: RTL

- Response-side collector for the MMU. It receives per-request response pulses from two producers per channel: the dispatcher (size-check failures) and the allocation/free engines (FDT alloc results, or_tree free results).
- It serializes them into the alloc and free response FIFOs without loss or reordering, and generates the almost_full backpressure that the dispatcher consumes.
- Producers have no ready signal, so the block absorbs up to two pulses per cycle per channel.

---
 rtl/mmu_rsp_merger.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/mmu_rsp_merger.sv
// Response merger: serializes dispatcher and engine response pulses into the alloc/free FIFOs.
// Optional ok/fail write counters are built when MMU_RSP_MERGE_STATS_EN is defined.

`ifndef REQ_ID_WIDTH
`define REQ_ID_WIDTH 8
`endif
`ifndef ALL_PAGE_IDX_WIDTH
`define ALL_PAGE_IDX_WIDTH 10
`endif
`ifndef FAIL_REASON_WIDTH
`define FAIL_REASON_WIDTH 3
`endif

module mmu_rsp_merger_chan #(
    parameter int DEPTH     = 8,
    parameter int AF_MARGIN = 2,
    parameter int W         = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         eng_we,
    input  logic [W-1:0] eng_data,
    input  logic         disp_we,
    input  logic [W-1:0] disp_data,
    input  logic         fifo_full,
    input  logic         fifo_almost_full,
    output logic         fifo_we,
    output logic [W-1:0] fifo_data,
    output logic         rsp_almost_full,
    output logic         drop
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = AW + 2;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] disp_ptr;
    logic [CW-1:0] count_q, count_d;
    logic [SW-1:0] free_slots;
    logic [1:0]    n_wr;
    logic          pop, eng_ok, disp_ok;
    logic          fifo_we_q;
    logic [W-1:0]  fifo_data_q;

    // A pop on this edge frees its slot for a same-edge write; engine entry has priority.
    always_comb begin
        pop        = (count_q != '0) && !fifo_full;
        free_slots = SW'(DEPTH) - SW'(count_q) + SW'(pop);
        eng_ok     = eng_we && (free_slots != '0);
        disp_ok    = disp_we && (free_slots > (eng_ok ? SW'(1) : SW'(0)));
        n_wr       = 2'(eng_ok) + 2'(disp_ok);
        disp_ptr   = eng_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        wr_ptr_d   = wr_ptr_q + AW'(n_wr);
        rd_ptr_d   = rd_ptr_q + AW'(pop);
        count_d    = count_q + CW'(n_wr) - CW'(pop);
        drop       = (eng_we && !eng_ok) || (disp_we && !disp_ok);
    end

    always_ff @(posedge clk) begin
        if (eng_ok) begin
            mem_q[wr_ptr_q] <= eng_data;
        end
        if (disp_ok) begin
            mem_q[disp_ptr] <= disp_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            fifo_we_q   <= 1'b0;
            fifo_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            fifo_we_q <= pop;
            if (pop) begin
                fifo_data_q <= mem_q[rd_ptr_q];
            end
        end
    end

    assign fifo_we         = fifo_we_q;
    assign fifo_data       = fifo_data_q;
    assign rsp_almost_full = fifo_almost_full || (count_q >= CW'(DEPTH - AF_MARGIN));
endmodule

module mmu_rsp_merger #(
    parameter int DEPTH     = 8,
    parameter int AF_MARGIN = 2,
    parameter int ALLOC_W   = `REQ_ID_WIDTH + `ALL_PAGE_IDX_WIDTH + 1 + `FAIL_REASON_WIDTH,
    parameter int FREE_W    = `REQ_ID_WIDTH + 1 + `FAIL_REASON_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               disp_alloc_we,
    input  logic [ALLOC_W-1:0] disp_alloc_data,
    input  logic               fdt_alloc_we,
    input  logic [ALLOC_W-1:0] fdt_alloc_data,
    input  logic               disp_free_we,
    input  logic [FREE_W-1:0]  disp_free_data,
    input  logic               tree_free_we,
    input  logic [FREE_W-1:0]  tree_free_data,
    input  logic               alloc_fifo_full,
    input  logic               alloc_fifo_almost_full,
    output logic               alloc_fifo_we,
    output logic [ALLOC_W-1:0] alloc_fifo_data,
    input  logic               free_fifo_full,
    input  logic               free_fifo_almost_full,
    output logic               free_fifo_we,
    output logic [FREE_W-1:0]  free_fifo_data,
    output logic               alloc_rsp_almost_full,
    output logic               free_rsp_almost_full,
    output logic               overflow
`ifdef MMU_RSP_MERGE_STATS_EN
    ,
    output logic [15:0]        alloc_ok_cnt,
    output logic [15:0]        alloc_fail_cnt,
    output logic [15:0]        free_ok_cnt,
    output logic [15:0]        free_fail_cnt
`endif
);
    logic alloc_drop, free_drop;
    logic overflow_q;

    mmu_rsp_merger_chan #(.DEPTH(DEPTH), .AF_MARGIN(AF_MARGIN), .W(ALLOC_W)) u_alloc (
        .clk              (clk),
        .rst_n            (rst_n),
        .eng_we           (fdt_alloc_we),
        .eng_data         (fdt_alloc_data),
        .disp_we          (disp_alloc_we),
        .disp_data        (disp_alloc_data),
        .fifo_full        (alloc_fifo_full),
        .fifo_almost_full (alloc_fifo_almost_full),
        .fifo_we          (alloc_fifo_we),
        .fifo_data        (alloc_fifo_data),
        .rsp_almost_full  (alloc_rsp_almost_full),
        .drop             (alloc_drop)
    );

    mmu_rsp_merger_chan #(.DEPTH(DEPTH), .AF_MARGIN(AF_MARGIN), .W(FREE_W)) u_free (
        .clk              (clk),
        .rst_n            (rst_n),
        .eng_we           (tree_free_we),
        .eng_data         (tree_free_data),
        .disp_we          (disp_free_we),
        .disp_data        (disp_free_data),
        .fifo_full        (free_fifo_full),
        .fifo_almost_full (free_fifo_almost_full),
        .fifo_we          (free_fifo_we),
        .fifo_data        (free_fifo_data),
        .rsp_almost_full  (free_rsp_almost_full),
        .drop             (free_drop)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_q || alloc_drop || free_drop;
        end
    end

    assign overflow = overflow_q;

`ifdef MMU_RSP_MERGE_STATS_EN
    localparam int FAIL_BIT = `FAIL_REASON_WIDTH;

    logic [15:0] alloc_ok_q, alloc_fail_q, free_ok_q, free_fail_q;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Counted on the registered FIFO write, classified by the payload fail bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alloc_ok_q   <= '0;
            alloc_fail_q <= '0;
            free_ok_q    <= '0;
            free_fail_q  <= '0;
        end else begin
            if (alloc_fifo_we) begin
                if (alloc_fifo_data[FAIL_BIT]) alloc_fail_q <= sat_inc(alloc_fail_q);
                else                           alloc_ok_q   <= sat_inc(alloc_ok_q);
            end
            if (free_fifo_we) begin
                if (free_fifo_data[FAIL_BIT]) free_fail_q <= sat_inc(free_fail_q);
                else                          free_ok_q   <= sat_inc(free_ok_q);
            end
        end
    end

    assign alloc_ok_cnt   = alloc_ok_q;
    assign alloc_fail_cnt = alloc_fail_q;
    assign free_ok_cnt    = free_ok_q;
    assign free_fail_cnt  = free_fail_q;
`endif
endmodule
